// File: rtl/cpu_pkg.sv
// cpu_pkg: shared codes for the register-write data path.
// - REGDST_* : 2-bit destination select codes driven by control
// - REG_*    : architectural register numbers with fixed roles
// - SP_INIT  : reset value of the stack pointer ($29)
// - wb_state_e : writeback slot state
package cpu_pkg;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;
  localparam logic [1:0] REGDST_SP = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam int SP_INIT = 227;

  typedef enum logic {WB_EMPTY, WB_FULL} wb_state_e;

  // Destination register number from the select code and instruction fields.
  function automatic logic [4:0] dst_decode(input logic [1:0] sel,
                                            input logic [4:0] rt_field,
                                            input logic [4:0] rd_field);
    case (sel)
      REGDST_RT: dst_decode = rt_field;
      REGDST_RD: dst_decode = rd_field;
      REGDST_RA: dst_decode = REG_RA;
      default:   dst_decode = REG_SP;
    endcase
  endfunction

endpackage

// File: rtl/reg_array.sv
// reg_array: 32 x DATA_W register storage.
// Ports:
//   clk, reset      : clock, synchronous active-low reset (all 0, $29 = SP_INIT)
//   we, wa, wd      : single synchronous write port
//   ra_a/ra_b       : async read addresses, rd_a/rd_b read data
// $0 handling lives in the caller; this array stores whatever it is told.
module reg_array
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SP_RST  = SP_INIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [4:0]        ra_a,
  input  logic [4:0]        ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] mem [32];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= (5'(i) == REG_SP) ? DATA_W'(SP_RST) : '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd_a = mem[ra_a];
  assign rd_b = mem[ra_b];

endmodule

// File: rtl/reg_writeback_bank.sv
// reg_writeback_bank: one-entry writeback slot in front of a 32-entry register bank.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   wr_valid/wr_ready     : write request handshake
//   wr_data, wr_dst_sel   : write word and destination select (rt, rd, $31, $29)
//   rt_field, rd_field    : instruction register fields used by the select
//   commit_hold           : keep the slot from draining this cycle
//   rs_addr/rs_data       : read port A (slot bypass, $0 forced to zero)
//   rt_addr/rt_data       : read port B (slot bypass, $0 forced to zero)
//   wb_pending            : slot holds an uncommitted write
module reg_writeback_bank
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SP_RST = SP_INIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_dst_sel,
  input  logic [4:0]        rt_field,
  input  logic [4:0]        rd_field,
  input  logic              commit_hold,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_pending
);

  wb_state_e         state;
  logic [4:0]        slot_addr;
  logic [DATA_W-1:0] slot_data;
  logic [DATA_W-1:0] bank_rs, bank_rt;

  logic accept, commit, bank_we;

  // A full slot that drains this cycle frees room for a new entry in the same edge.
  assign wr_ready   = (state == WB_EMPTY) | ~commit_hold;
  assign accept     = wr_valid & wr_ready;
  assign commit     = (state == WB_FULL) & ~commit_hold;
  // $0 writes complete the handshake but never reach storage.
  assign bank_we    = commit & (slot_addr != REG_ZERO);
  assign wb_pending = (state == WB_FULL);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= WB_EMPTY;
      slot_addr <= REG_ZERO;
      slot_data <= '0;
    end else begin
      if (accept) begin
        state     <= WB_FULL;
        slot_addr <= dst_decode(wr_dst_sel, rt_field, rd_field);
        slot_data <= wr_data;
      end else if (commit) begin
        state <= WB_EMPTY;
      end
    end
  end

  reg_array #(.DATA_W(DATA_W), .SP_RST(SP_RST)) u_regs (
    .clk  (clk),
    .reset(reset),
    .we   (bank_we),
    .wa   (slot_addr),
    .wd   (slot_data),
    .ra_a (rs_addr),
    .ra_b (rt_addr),
    .rd_a (bank_rs),
    .rd_b (bank_rt)
  );

  // Pending slot data shadows the bank so a just-accepted write is readable next cycle.
  always_comb begin
    rs_data = '0;
    if (rs_addr != REG_ZERO)
      rs_data = (state == WB_FULL && rs_addr == slot_addr) ? slot_data : bank_rs;
  end

  always_comb begin
    rt_data = '0;
    if (rt_addr != REG_ZERO)
      rt_data = (state == WB_FULL && rt_addr == slot_addr) ? slot_data : bank_rt;
  end

endmodule

// File: tb/tb_reg_writeback_bank.sv
// Bench for reg_writeback_bank: directed vectors, an architectural model
// (register file as software sees it, updated at request acceptance) compared
// every cycle, plus literal checks at key points.
module tb_reg_writeback_bank;

  logic        clk = 0;
  logic        reset = 0;
  logic        wr_valid = 0;
  logic        wr_ready;
  logic [31:0] wr_data = 0;
  logic [1:0]  wr_dst_sel = 0;
  logic [4:0]  rt_field = 0, rd_field = 0;
  logic        commit_hold = 0;
  logic [4:0]  rs_addr = 0, rt_addr = 0;
  logic [31:0] rs_data, rt_data;
  logic        wb_pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_writeback_bank dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_dst_sel(wr_dst_sel), .rt_field(rt_field),
    .rd_field(rd_field), .commit_hold(commit_hold), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data), .wb_pending(wb_pending)
  );

  // Architectural model: arch holds what a reader must see, which is the last
  // accepted write to each register; pend says a write is still in flight.
  logic [31:0] arch [32];
  logic        pend = 0;
  logic        m_init = 0;

  function automatic logic [4:0] m_dst(input logic [1:0] s, input logic [4:0] rt, input logic [4:0] rd);
    case (s)
      2'd0: return rt;
      2'd1: return rd;
      2'd2: return 5'd31;
      default: return 5'd29;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (a == 0) ? 32'd0 : arch[a];
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) arch[i] <= (i == 29) ? 32'd227 : 32'd0;
      pend   <= 0;
      m_init <= 1;
    end else if (m_init) begin
      if (wr_valid && (!pend || !commit_hold)) begin
        if (m_dst(wr_dst_sel, rt_field, rd_field) != 0)
          arch[m_dst(wr_dst_sel, rt_field, rd_field)] <= wr_data;
        pend <= 1;
      end else if (pend && !commit_hold) begin
        pend <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("cyc rs_data", rs_data, m_read(rs_addr));
      chk("cyc rt_data", rt_data, m_read(rt_addr));
      chk("cyc wb_pending", {31'd0, wb_pending}, {31'd0, pend});
      chk("cyc wr_ready", {31'd0, wr_ready}, {31'd0, (!pend || !commit_hold)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] sel, input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] d);
    wr_valid = 1; wr_dst_sel = sel; rt_field = rt; rd_field = rd; wr_data = d;
  endtask

  initial begin
    // Reset
    reset = 0; rs_addr = 29; rt_addr = 5;
    step(); step();
    chk("rst sp", rs_data, 32'd227);
    chk("rst r5", rt_data, 32'd0);
    chk("rst ready", {31'd0, wr_ready}, 32'd1);
    chk("rst pending", {31'd0, wb_pending}, 32'd0);
    reset = 1;
    step();

    // Write rd field
    req(2'd1, 5'd0, 5'd8, 32'hDEADBEEF); rt_addr = 8;
    step(); wr_valid = 0;
    chk("wr8 pending", {31'd0, wb_pending}, 32'd1);
    chk("wr8 bypass", rt_data, 32'hDEADBEEF);
    step();
    chk("wr8 drained", {31'd0, wb_pending}, 32'd0);
    chk("wr8 bank", rt_data, 32'hDEADBEEF);

    // Back-to-back
    req(2'd1, 5'd0, 5'd9, 32'd1); step();
    chk("b2b ready1", {31'd0, wr_ready}, 32'd1);
    req(2'd1, 5'd0, 5'd10, 32'd2); step();
    chk("b2b ready2", {31'd0, wr_ready}, 32'd1);
    req(2'd1, 5'd0, 5'd9, 32'd3); step();
    wr_valid = 0; step();
    rs_addr = 9; rt_addr = 10; #1;
    chk("b2b r9", rs_data, 32'd3);
    chk("b2b r10", rt_data, 32'd2);
    chk("b2b idle", {31'd0, wb_pending}, 32'd0);

    // Stall
    req(2'd1, 5'd0, 5'd11, 32'h55); rs_addr = 11; rt_addr = 12;
    step();
    commit_hold = 1;
    req(2'd1, 5'd0, 5'd12, 32'h77);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall ready", {31'd0, wr_ready}, 32'd0);
      chk("stall bypass", rs_data, 32'h55);
      chk("stall ignored", rt_data, 32'd0);
    end
    commit_hold = 0;
    step(); wr_valid = 0;
    chk("release pending", {31'd0, wb_pending}, 32'd1);
    chk("release r12", rt_data, 32'h77);
    chk("release r11", rs_data, 32'h55);
    step();
    chk("release drained", {31'd0, wb_pending}, 32'd0);

    // $0 and jal / sp
    req(2'd0, 5'd0, 5'd3, 32'd7); rs_addr = 0;
    step();
    chk("r0 zero", rs_data, 32'd0);
    chk("r0 captured", {31'd0, wb_pending}, 32'd1);
    req(2'd2, 5'd1, 5'd2, 32'h40); step();
    req(2'd3, 5'd1, 5'd2, 32'd200); step();
    wr_valid = 0; step();
    rs_addr = 31; rt_addr = 29; #1;
    chk("jal r31", rs_data, 32'h40);
    chk("sp r29", rt_data, 32'd200);
    rt_addr = 0; #1;
    chk("r0 after", rt_data, 32'd0);

    // Reset mid-operation, with a request offered during reset
    req(2'd1, 5'd0, 5'd12, 32'h99); rs_addr = 12; rt_addr = 29;
    step();
    wr_valid = 0; commit_hold = 1;
    chk("mid full", rs_data, 32'h99);
    reset = 0;
    req(2'd1, 5'd0, 5'd13, 32'hAA);
    step();
    wr_valid = 0; reset = 1;
    chk("mid r12", rs_data, 32'd0);
    chk("mid empty", {31'd0, wb_pending}, 32'd0);
    chk("mid ready", {31'd0, wr_ready}, 32'd1);
    chk("mid sp", rt_data, 32'd227);
    commit_hold = 0; rs_addr = 13; rt_addr = 8;
    step();
    chk("mid r13", rs_data, 32'd0);
    chk("mid r8", rt_data, 32'd0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
